param_stack: RTL and testbench

Parametrised hardware stack for the RV32I core's call/data stack. Stores DEPTH words of DATA_W bits, grows downward from BASE_ADDR, and mirrors the architectural stack pointer. Compared with the fixed 32×256 stack, this block adds:
- a combined push+pop (replace-top) operation;
- a non-destructive peek;
- a synchronous flush;
- sticky overflow/underflow error flags;
- occupancy and almost-full reporting.

---
 rtl/stack_pkg.sv | 36 +++
 rtl/stack_ram_1r1w.sv | 28 ++
 rtl/param_stack.sv | 171 +++++++++++++++++
 tb/tb_param_stack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the parametrised stack.
package stack_pkg;

  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefDepth     = 256;
  localparam int unsigned DefSpW       = 17;
  localparam int unsigned DefBaseAddr  = 102300;
  localparam int unsigned DefWordBytes = 4;

  // One operation per cycle, resolved from the raw command lines.
  typedef enum logic [2:0] {
    OpNop,
    OpPush,
    OpPop,
    OpReplace,
    OpBypass,
    OpPeek
  } op_e;

  // Source of data_out: reset zero, RAM read register, or bypass register.
  typedef enum logic [1:0] {
    SelZero,
    SelRam,
    SelBypass
  } dsel_e;

  // push+pop becomes replace, or bypass when there is nothing to replace.
  function automatic op_e decode_op(logic push, logic pop, logic peek, logic empty);
    if (push && pop) return empty ? OpBypass : OpReplace;
    if (push)        return OpPush;
    if (pop)         return OpPop;
    if (peek)        return OpPeek;
    return OpNop;
  endfunction

endpackage

// File: rtl/stack_ram_1r1w.sv
// Stack storage: one synchronous write port, one synchronous read port.
// A read and write to the same address on one edge returns the old word.
module stack_ram_1r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking semantics give read-before-write on collision.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_stack.sv
// Downward-growing hardware stack with replace, bypass, peek, flush and
// sticky error flags. Mirrors the architectural stack pointer.
module param_stack
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned SP_W       = DefSpW,
  parameter int unsigned BASE_ADDR  = DefBaseAddr,
  parameter int unsigned WORD_BYTES = DefWordBytes,
  parameter int unsigned AF_LEVEL   = DEPTH - 4,
  parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              peek_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              valid_out_o,
  output logic [SP_W-1:0]   sp_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0]     count_q, count_d, cnt_m1;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              full_q, empty_q, af_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              valid_q, valid_d;
  dsel_e             sel_q, sel_d;
  logic [DATA_W-1:0] byp_q, byp_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr, top_addr;
  op_e               op;

  assign cnt_m1   = count_q - CW'(1);
  assign top_addr = cnt_m1[AW-1:0];

  stack_ram_1r1w #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(data_in_i),
    .re_i   (ram_re),
    .raddr_i(top_addr),
    .rdata_o(ram_rdata)
  );

  // Decode the command and compute next state; reset/clear suppress all RAM access.
  always_comb begin
    op        = decode_op(push_i, pop_i, peek_i, empty_q);
    if (reset_i || clear_i) op = OpNop;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    valid_d   = 1'b0;
    sel_d     = sel_q;
    byp_d     = byp_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = count_q[AW-1:0];
    unique case (op)
      OpPush: begin
        if (full_q) begin
          ovf_d = 1'b1;
        end else begin
          ram_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OpPop: begin
        if (empty_q) begin
          unf_d = 1'b1;
        end else begin
          ram_re  = 1'b1;
          valid_d = 1'b1;
          sel_d   = SelRam;
          count_d = cnt_m1;
        end
      end
      OpReplace: begin
        ram_re    = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = top_addr;
        valid_d   = 1'b1;
        sel_d     = SelRam;
      end
      OpBypass: begin
        valid_d = 1'b1;
        byp_d   = data_in_i;
        sel_d   = SelBypass;
      end
      OpPeek: begin
        if (empty_q) begin
          unf_d = 1'b1;
        end else begin
          ram_re  = 1'b1;
          valid_d = 1'b1;
          sel_d   = SelRam;
        end
      end
      default: ;
    endcase
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      valid_d = 1'b0;
    end
    sp_d = SP_W'(BASE_ADDR) - SP_W'(count_d) * SP_W'(WORD_BYTES);
  end

  // State and registered status, derived flags follow count_d on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      sp_q    <= SP_W'(BASE_ADDR);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= SelZero;
      byp_q   <= '0;
    end else begin
      count_q <= count_d;
      sp_q    <= sp_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= CW'(AF_LEVEL));
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      byp_q   <= byp_d;
    end
  end

  always_comb begin
    unique case (sel_q)
      SelRam:    data_out_o = ram_rdata;
      SelBypass: data_out_o = byp_q;
      default:   data_out_o = '0;
    endcase
  end

  assign valid_out_o   = valid_q;
  assign sp_o          = sp_q;
  assign count_o       = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed vector table plus hand sequences and a queue-model random run.
module tb_param_stack;
  import stack_pkg::*;

  localparam int Depth = 256;
  localparam int Base  = 102300;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0, push = 1'b0, pop = 1'b0, peek = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        valid_out, full, empty, almost_full, overflow, underflow;
  logic [16:0] sp;
  logic [8:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_stack dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (clear),
    .push_i       (push),
    .pop_i        (pop),
    .peek_i       (peek),
    .data_in_i    (data_in),
    .data_out_o   (data_out),
    .valid_out_o  (valid_out),
    .sp_o         (sp),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .almost_full_o(almost_full),
    .overflow_o   (overflow),
    .underflow_o  (underflow)
  );

  typedef struct {
    logic        rst, clr, pu, po, pk;
    logic [31:0] din;
    logic        ev;
    logic [31:0] ed;
    int          ec;
    logic        eo, eu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic clr, logic pu, logic po, logic pk,
                              logic [31:0] din, logic ev, logic [31:0] ed, int ec,
                              logic eo, logic eu);
    vec_t v;
    v.rst = rst; v.clr = clr; v.pu = pu; v.po = po; v.pk = pk; v.din = din;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one command across a rising edge, leaving time 1 unit after the edge.
  task automatic drive(input logic rst, input logic clr, input logic pu, input logic po,
                       input logic pk, input logic [31:0] din);
    @(negedge clk);
    reset = rst; clear = clr; push = pu; pop = po; peek = pk; data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] ed,
                           input int ec, input logic eo, input logic eu);
    chk({tag, ".valid"}, 32'(valid_out), 32'(ev));
    chk({tag, ".data"}, data_out, ed);
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".sp"}, 32'(sp), 32'(Base - ec * 4));
    chk({tag, ".empty"}, 32'(empty), 32'(ec == 0));
    chk({tag, ".full"}, 32'(full), 32'(ec == Depth));
    chk({tag, ".afull"}, 32'(almost_full), 32'(ec >= Depth - 4));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    chk({tag, ".unf"}, 32'(underflow), 32'(eu));
  endtask

  // Reference queue model for the random run.
  logic [31:0] q[$];
  logic [31:0] m_data;
  logic        m_valid, m_ovf, m_unf;

  task automatic model_step(input logic clr, input logic pu, input logic po, input logic pk,
                            input logic [31:0] din);
    op_e mop;
    m_valid = 1'b0;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (pu && po)  mop = (q.size() == 0) ? OpBypass : OpReplace;
    else if (pu)   mop = OpPush;
    else if (po)   mop = OpPop;
    else if (pk)   mop = OpPeek;
    else           mop = OpNop;
    case (mop)
      OpBypass:  begin m_data = din; m_valid = 1'b1; end
      OpReplace: begin m_data = q[q.size()-1]; q[q.size()-1] = din; m_valid = 1'b1; end
      OpPush:    if (q.size() == Depth) m_ovf = 1'b1; else q.push_back(din);
      OpPop:     if (q.size() == 0) m_unf = 1'b1;
                 else begin m_data = q.pop_back(); m_valid = 1'b1; end
      OpPeek:    if (q.size() == 0) m_unf = 1'b1;
                 else begin m_data = q[q.size()-1]; m_valid = 1'b1; end
      default: ;
    endcase
  endtask

  initial begin
    //          rst clr pu po pk din      ev ed       ec eo eu
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hA1, 0, 32'h0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hB2, 0, 32'h0,  2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hC3, 0, 32'h0,  3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  1, 32'hC3, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  1, 32'hB2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  1, 32'hA1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  0, 32'hA1, 0, 0, 1));  // pop on empty
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h77, 1, 32'h77, 0, 0, 1));  // bypass
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h10, 0, 32'h77, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,  1, 32'h10, 1, 0, 1));  // peek
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,  1, 32'h10, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,  1, 32'h10, 0, 0, 1));  // peek+pop = pop
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h10, 0, 0, 1));  // peek on empty
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h20, 0, 32'h10, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h21, 1, 32'h20, 1, 0, 1));  // replace
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h22, 1, 32'h21, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  1, 32'h22, 0, 0, 1));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 32'(i), 0, 32'h22, i, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h22, 0, 0, 0));  // clear
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h99, 0, 32'h22, 0, 0, 0));  // clear drops push
    for (int i = 6; i <= 10; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 32'(i), 0, 32'h22, i - 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  1, 32'hA,  4, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h5A, 0, 32'h0,  0, 0, 0));  // reset drops push

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].pu, vecs[i].po, vecs[i].pk, vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].eo,
                vecs[i].eu);
    end

    // Fill to full, overflow, then replace at full.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < Depth; i++) begin
      drive(0, 0, 1, 0, 0, 32'h1000 + 32'(i));
      chk_state($sformatf("fill%0d", i), 1'b0, 32'h0, i + 1, 1'b0, 1'b0);
    end
    drive(0, 0, 1, 0, 0, 32'hDEAD);
    chk_state("overflow", 1'b0, 32'h0, Depth, 1'b1, 1'b0);
    drive(0, 0, 1, 1, 0, 32'h55);
    chk_state("replace_full", 1'b1, 32'h10FF, Depth, 1'b1, 1'b0);
    drive(0, 0, 0, 1, 0, 0);
    chk_state("pop_after_replace", 1'b1, 32'h55, Depth - 1, 1'b1, 1'b0);

    // Random run against the queue model.
    drive(1, 0, 0, 0, 0, 0);
    q.delete();
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic rc, rpu, rpo, rpk;
      logic [31:0] rd;
      rc  = ($urandom_range(63) == 0);
      rpu = ($urandom_range(9) < 5);
      rpo = ($urandom_range(9) < 4);
      rpk = ($urandom_range(9) < 3);
      rd  = $urandom;
      drive(0, rc, rpu, rpo, rpk, rd);
      model_step(rc, rpu, rpo, rpk, rd);
      chk_state($sformatf("rnd%0d", c), m_valid, m_data, q.size(), m_ovf, m_unf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
